// File: rtl/trap_pkg.sv
// Shared helpers for the trapezoidal shaper: counter sizing and output clipping.
package trap_pkg;

  localparam int CLIP_W = 64;

  typedef struct packed {
    logic              sat;
    logic [CLIP_W-1:0] val;
  } clip_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic signed [CLIP_W-1:0] sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [CLIP_W-1:0] sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  // Clamp a sign-extended accumulator value into an out_w-bit signed range.
  function automatic clip_t sat_clip(input logic signed [CLIP_W-1:0] t, input int out_w);
    clip_t c;
    c.sat = 1'b0;
    c.val = t;
    if (t > sat_max(out_w)) begin
      c.sat = 1'b1;
      c.val = sat_max(out_w);
    end else if (t < sat_min(out_w)) begin
      c.sat = 1'b1;
      c.val = sat_min(out_w);
    end
    return c;
  endfunction

endpackage

// File: rtl/trap_delay_line.sv
// Valid-gated sample delay line with taps at K, L and K+L samples back.
module trap_delay_line #(
  parameter int W = 16,
  parameter int K = 4,
  parameter int L = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] tap_k,
  output logic [W-1:0] tap_l,
  output logic [W-1:0] tap_kl
);

  localparam int N = K + L;

  // line[0] holds the previous accepted sample, line[N-1] the oldest.
  logic [N-1:0][W-1:0] line;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line <= '0;
    end else if (clear) begin
      line <= '0;
    end else if (shift) begin
      line <= {line[N-2:0], d};
    end
  end

  assign tap_k  = line[K-1];
  assign tap_l  = line[L-1];
  assign tap_kl = line[N-1];

endmodule

// File: rtl/trap_shaper_p.sv
// Trapezoidal shaper with pole-zero correction, three arithmetic stages plus
// a registered saturating output; sits after the ADC sample register.
module trap_shaper_p
  import trap_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 16,
  parameter int K         = 4,
  parameter int L         = 5,
  parameter int M_SHIFT   = 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             sat,
  output logic             primed
);

  localparam int N     = K + L;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  // Handshake: in_valid is a strobe with no back-pressure; every sample taken
  // while clear=0 yields exactly one out_valid pulse three edges later.
  logic accept;
  assign accept = in_valid & ~clear;

  logic [IN_W-1:0] tap_k, tap_l, tap_kl;

  trap_delay_line #(.W(IN_W), .K(K), .L(L)) u_line (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .shift  (accept),
    .d      (in),
    .tap_k  (tap_k),
    .tap_l  (tap_l),
    .tap_kl (tap_kl)
  );

  function automatic logic signed [ACC_W-1:0] ext(input logic [IN_W-1:0] x);
    return $signed({{(ACC_W-IN_W){1'b0}}, x});
  endfunction

  logic signed [ACC_W-1:0] d_next, p_next, t;
  logic signed [CLIP_W-1:0] t64;
  clip_t clip;

  logic                    v1, v2, v3;
  logic signed [ACC_W-1:0] d1, p, r, s;
  logic [CNT_W-1:0]        cnt;

  always_comb begin
    d_next = ext(in) - ext(tap_k) - ext(tap_l) + ext(tap_kl);
    p_next = p + d1;
    t      = s >>> OUT_SHIFT;
    t64    = {{(CLIP_W-ACC_W){t[ACC_W-1]}}, t};
    clip   = sat_clip(t64, OUT_W);
  end

  // p and s wrap freely so the recursion cancels exactly after each pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      d1 <= '0; p <= '0; r <= '0; s <= '0;
      out <= '0; sat <= 1'b0; out_valid <= 1'b0;
      cnt <= '0;
    end else if (clear) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      d1 <= '0; p <= '0; r <= '0; s <= '0;
      out <= '0; sat <= 1'b0; out_valid <= 1'b0;
      cnt <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      out_valid <= v3;
      if (accept) begin
        d1 <= d_next;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if (v1) begin
        p <= p_next;
        r <= p_next + (d1 <<< M_SHIFT);
      end
      if (v2) s <= s + r;
      if (v3) begin
        out <= OUT_W'(clip.val);
        sat <= clip.sat;
      end else begin
        sat <= 1'b0;
      end
    end
  end

  assign primed = (cnt == CNT_MAX);

endmodule

// File: tb/tb_trap_shaper_p.sv
// Directed bench for trap_shaper_p: default instance plus an OUT_SHIFT=1 twin.
module tb_trap_shaper_p;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out, out2;
  logic        out_valid, out_valid2, sat, sat2, primed, primed2;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  logic signed [31:0] exp_q[$];
  logic               vhist[$];
  logic signed [31:0] last_out = 0;

  // Hand-computed s sequences for K=4, L=5, M=16.
  int step_s[12] = '{1700, 3500, 5400, 7400, 7800, 6500, 5100, 3600, 2000, 2000, 2000, 2000};
  int imp_s[14]  = '{1700, 1800, 1900, 2000, 400, -1300, -1400, -1500, -1600, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  trap_shaper_p u_dut (
    .clk(clk), .reset(reset), .clear(clear), .in(in), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .sat(sat), .primed(primed)
  );

  trap_shaper_p #(.OUT_SHIFT(1)) u_dut_sh (
    .clk(clk), .reset(reset), .clear(clear), .in(in), .in_valid(in_valid),
    .out(out2), .out_valid(out_valid2), .sat(sat2), .primed(primed2)
  );

  task automatic chk_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] clip(input logic signed [31:0] t);
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  function automatic logic clipped(input logic signed [31:0] t);
    return (t > 32767) || (t < -32768);
  endfunction

  task automatic step(input logic [15:0] x, input logic v);
    logic exp_v;
    logic signed [31:0] s;
    in = x;
    in_valid = v;
    @(posedge clk); #1;
    vhist.push_back(v);
    if (v) n_acc++;
    exp_v = (vhist.size() >= 4) ? vhist[vhist.size()-4] : 1'b0;
    chk_bit("out_valid", out_valid, exp_v);
    chk_bit("out_valid_sh", out_valid2, exp_v);
    chk_bit("primed", primed, n_acc >= 9);
    chk_bit("primed_sh", primed2, n_acc >= 9);
    if (exp_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=valid expected=no_pending_sample");
      end else begin
        s = exp_q.pop_front();
        chk_val("out", 32'($signed(out)), clip(s));
        chk_bit("sat", sat, clipped(s));
        chk_val("out_sh", 32'($signed(out2)), clip(s >>> 1));
        chk_bit("sat_sh", sat2, clipped(s >>> 1));
      end
    end else begin
      chk_val("out_hold", 32'($signed(out)), last_out);
      chk_bit("sat_idle", sat, 1'b0);
    end
    last_out = 32'($signed(out));
  endtask

  task automatic drain();
    repeat (3) step(16'd0, 1'b0);
    chk_val("sb_drain", exp_q.size(), 0);
  endtask

  task automatic restart_model();
    exp_q.delete();
    vhist.delete();
    n_acc = 0;
    last_out = 0;
  endtask

  task automatic do_clear(input logic [15:0] x);
    in = x;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    restart_model();
    chk_val("clr_out", 32'($signed(out)), 0);
    chk_bit("clr_valid", out_valid, 1'b0);
    chk_bit("clr_sat", sat, 1'b0);
    chk_bit("clr_primed", primed, 1'b0);
    chk_bit("clr_primed_sh", primed2, 1'b0);
  endtask

  task automatic push_step();
    foreach (step_s[i]) exp_q.push_back(step_s[i]);
  endtask

  task automatic push_imp(input int scale);
    foreach (imp_s[i]) exp_q.push_back(imp_s[i] * scale);
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    chk_val("rst_out", 32'($signed(out)), 0);
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_bit("rst_sat", sat, 1'b0);
    chk_bit("rst_primed", primed, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Step response
    push_step();
    repeat (12) step(16'd100, 1'b1);
    drain();
    do_clear(16'd555);

    // Impulse response, no residual afterwards
    push_imp(1);
    step(16'd100, 1'b1);
    repeat (13) step(16'd0, 1'b1);
    drain();

    // Same impulse with bubbles between samples
    push_imp(1);
    step(16'd100, 1'b1);
    step(16'd0, 1'b0);
    repeat (13) begin
      step(16'd0, 1'b1);
      step(16'd0, 1'b0);
    end
    drain();

    // Saturation: peak 40000 clips at OUT_SHIFT=0, fits at OUT_SHIFT=1
    push_imp(20);
    step(16'd2000, 1'b1);
    repeat (13) step(16'd0, 1'b1);
    drain();

    // Clear presented with the 3rd impulse sample
    exp_q.push_back(1700);
    exp_q.push_back(1800);
    step(16'd100, 1'b1);
    step(16'd0, 1'b1);
    do_clear(16'd0);
    repeat (3) step(16'd0, 1'b0);
    push_imp(1);
    step(16'd100, 1'b1);
    repeat (13) step(16'd0, 1'b1);
    drain();

    // Asynchronous reset between edges during a step
    do_clear(16'd0);
    push_step();
    repeat (10) step(16'd100, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_val("async_out", 32'($signed(out)), 0);
    chk_bit("async_valid", out_valid, 1'b0);
    chk_bit("async_sat", sat, 1'b0);
    chk_bit("async_primed", primed, 1'b0);
    #3 reset = 1'b1;
    restart_model();
    push_step();
    repeat (12) step(16'd100, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
